sensor_baseline: RTL and testbench

SENSOR_BASELINE -- requirements
Module: sensor_baseline

---
 rtl/sensor_baseline.sv | 180 ++++++++++++++++++
 tb/tb_sensor_baseline.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sensor_baseline.sv
// Sensor baseline capture: block-average calibration (CALIB) then moving-average filtering (RUN).
// Baseline port is ref_level since "ref" is reserved; SENSOR_BASELINE_DRIFT_TRACK_EN adds drift tracking.
module sensor_baseline #(
  parameter int unsigned W        = 12,
  parameter int unsigned CAL_LOG2 = 4,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic         clk_16ms,
  input  logic         rst,
  input  logic         enable,
  input  logic         recal,
  input  logic [W-1:0] sample_in,
  input  logic         sample_valid,
  output logic [W-1:0] sen,
  output logic [W-1:0] ref_level,
  output logic         ref_valid,
  output logic         busy
);

  localparam int unsigned CAL_N = 1 << CAL_LOG2;
  localparam int unsigned AVG_N = 1 << AVG_LOG2;
  localparam int unsigned AW    = W + CAL_LOG2;
  localparam int unsigned SW    = W + AVG_LOG2;
  localparam int unsigned CW    = (CAL_LOG2 > 0) ? CAL_LOG2 : 1;
  localparam int unsigned PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALIB = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t         state_q, state_nxt;
  logic [AW-1:0]  acc_q, acc_nxt;
  logic [CW-1:0]  cnt_q, cnt_nxt;
  logic [PW-1:0]  ptr_q, ptr_nxt;
  logic [SW-1:0]  sum_q, sum_nxt;
  logic [W-1:0]   win_q   [AVG_N];
  logic [W-1:0]   win_nxt [AVG_N];
  logic [W-1:0]   sen_q, sen_nxt;
  logic [W-1:0]   ref_q, ref_nxt;
  logic           ref_valid_q, ref_valid_nxt;
  logic           busy_q;

  logic [AW-1:0]  acc_add;
  logic           cal_last;
  logic [SW-1:0]  run_sum;
  logic [W-1:0]   run_sen;
  logic [W-1:0]   load_ref;
  logic           load_run;
  logic           start_cal;

  assign sen       = sen_q;
  assign ref_level = ref_q;
  assign ref_valid = ref_valid_q;
  assign busy      = busy_q;

  // Next-state and datapath update; everything holds unless a transition or sample says otherwise.
  always_comb begin
    state_nxt     = state_q;
    acc_nxt       = acc_q;
    cnt_nxt       = cnt_q;
    ptr_nxt       = ptr_q;
    sum_nxt       = sum_q;
    win_nxt       = win_q;
    sen_nxt       = sen_q;
    ref_nxt       = ref_q;
    ref_valid_nxt = ref_valid_q;
    acc_add       = acc_q + AW'(sample_in);
    cal_last      = (cnt_q == CW'(CAL_N - 1));
    run_sum       = sum_q - SW'(win_q[ptr_q]) + SW'(sample_in);
    run_sen       = W'(run_sum >> AVG_LOG2);
    load_ref      = '0;
    load_run      = 1'b0;
    start_cal     = 1'b0;

    if (!enable) begin
      state_nxt = IDLE;
    end else if (recal) begin
      start_cal = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (ref_valid_q) begin
            load_run = 1'b1;
            load_ref = ref_q;
          end else begin
            start_cal = 1'b1;
          end
        end
        CALIB: begin
          if (sample_valid) begin
            if (cal_last) begin
              ref_nxt       = W'(acc_add >> CAL_LOG2);
              ref_valid_nxt = 1'b1;
              load_run      = 1'b1;
              load_ref      = W'(acc_add >> CAL_LOG2);
            end else begin
              acc_nxt = acc_add;
              cnt_nxt = cnt_q + CW'(1);
            end
          end
        end
        RUN: begin
          if (sample_valid) begin
            win_nxt[ptr_q] = sample_in;
            sum_nxt        = run_sum;
            sen_nxt        = run_sen;
            ptr_nxt        = (ptr_q == PW'(AVG_N - 1)) ? '0 : ptr_q + PW'(1);
`ifdef SENSOR_BASELINE_DRIFT_TRACK_EN
            // Nudge the baseline one LSB toward the filtered value once per calibration-length block.
            if (cal_last) begin
              cnt_nxt = '0;
              if ((run_sen > ref_q) && (ref_q != {W{1'b1}})) begin
                ref_nxt = ref_q + W'(1);
              end else if ((run_sen < ref_q) && (ref_q != '0)) begin
                ref_nxt = ref_q - W'(1);
              end
            end else begin
              cnt_nxt = cnt_q + CW'(1);
            end
`endif
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (start_cal) begin
      state_nxt     = CALIB;
      acc_nxt       = '0;
      cnt_nxt       = '0;
      ref_valid_nxt = 1'b0;
    end

    // RUN entry: window filled with the baseline so the filter starts settled.
    if (load_run) begin
      state_nxt = RUN;
      for (int i = 0; i < AVG_N; i++) begin
        win_nxt[i] = load_ref;
      end
      sum_nxt = SW'(load_ref) << AVG_LOG2;
      sen_nxt = load_ref;
      ptr_nxt = '0;
      cnt_nxt = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_16ms) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      sum_q       <= '0;
      sen_q       <= '0;
      ref_q       <= '0;
      ref_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < AVG_N; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q     <= state_nxt;
      acc_q       <= acc_nxt;
      cnt_q       <= cnt_nxt;
      ptr_q       <= ptr_nxt;
      sum_q       <= sum_nxt;
      sen_q       <= sen_nxt;
      ref_q       <= ref_nxt;
      ref_valid_q <= ref_valid_nxt;
      busy_q      <= (state_nxt == CALIB);
      for (int i = 0; i < AVG_N; i++) begin
        win_q[i] <= win_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_sensor_baseline.sv
// Directed bench for sensor_baseline (W=12, CAL_LOG2=4, AVG_LOG2=2), one task per scenario.
module tb_sensor_baseline;

  logic        clk_16ms;
  logic        rst;
  logic        enable;
  logic        recal;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic [11:0] sen;
  logic [11:0] ref_level;
  logic        ref_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  sensor_baseline #(.W(12), .CAL_LOG2(4), .AVG_LOG2(2)) dut (
    .clk_16ms    (clk_16ms),
    .rst         (rst),
    .enable      (enable),
    .recal       (recal),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sen         (sen),
    .ref_level   (ref_level),
    .ref_valid   (ref_valid),
    .busy        (busy)
  );

  initial begin
    clk_16ms = 1'b0;
    forever #5 clk_16ms = ~clk_16ms;
  end

  task automatic tick();
    @(posedge clk_16ms);
    #1;
  endtask

  task automatic send(input logic [11:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic sends(input logic [11:0] v, input int n);
    for (int k = 0; k < n; k++) send(v);
  endtask

  task automatic pulse_recal();
    recal = 1'b1;
    tick();
    recal = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; recal = 1'b1; sample_valid = 1'b1; sample_in = 12'd777;
    tick(); tick();
    total++; if (sen !== 12'd0) begin bad++; $display("FAIL reset_sen: got %0d want 0", sen); end
    total++; if (ref_level !== 12'd0) begin bad++; $display("FAIL reset_ref: got %0d want 0", ref_level); end
    total++; if (ref_valid !== 1'b0) begin bad++; $display("FAIL reset_ref_valid: got %b want 0", ref_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0; enable = 1'b0; recal = 1'b0; sample_valid = 1'b0; sample_in = '0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_calib();
    enable = 1'b1;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL calib_enter_busy: got %b want 1", busy); end
    sends(12'd1000, 15);
    total++; if (ref_valid !== 1'b0) begin bad++; $display("FAIL calib15_ref_valid: got %b want 0", ref_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL calib15_busy: got %b want 1", busy); end
    send(12'd1000);
    total++; if (ref_level !== 12'd1000) begin bad++; $display("FAIL calib_ref: got %0d want 1000", ref_level); end
    total++; if (ref_valid !== 1'b1) begin bad++; $display("FAIL calib_ref_valid: got %b want 1", ref_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL calib_done_busy: got %b want 0", busy); end
    total++; if (sen !== 12'd1000) begin bad++; $display("FAIL calib_sen: got %0d want 1000", sen); end
  endtask

  task automatic test_calib_values();
    pulse_recal();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL recal_busy: got %b want 1", busy); end
    total++; if (ref_valid !== 1'b0) begin bad++; $display("FAIL recal_ref_valid: got %b want 0", ref_valid); end
    total++; if (ref_level !== 12'd1000) begin bad++; $display("FAIL recal_ref_hold: got %0d want 1000", ref_level); end
    for (int i = 0; i < 16; i++) send(12'(i));
    total++; if (ref_level !== 12'd7) begin bad++; $display("FAIL ramp_ref: got %0d want 7", ref_level); end
    total++; if (ref_valid !== 1'b1) begin bad++; $display("FAIL ramp_ref_valid: got %b want 1", ref_valid); end
    pulse_recal();
    sends(12'd4095, 16);
    total++; if (ref_level !== 12'd4095) begin bad++; $display("FAIL max_ref: got %0d want 4095", ref_level); end
    total++; if (sen !== 12'd4095) begin bad++; $display("FAIL max_sen: got %0d want 4095", sen); end
  endtask

  task automatic test_run_avg();
    logic [11:0] exp_sen;
    pulse_recal();
    sends(12'd1000, 16);
    total++; if (ref_level !== 12'd1000) begin bad++; $display("FAIL run_ref: got %0d want 1000", ref_level); end
    for (int k = 1; k <= 4; k++) begin
      send(12'd1400);
      exp_sen = 12'(1000 + 100 * k);
      total++; if (sen !== exp_sen) begin bad++; $display("FAIL run_sen_%0d: got %0d want %0d", k, sen, exp_sen); end
    end
    tick(); tick();
    total++; if (sen !== 12'd1400) begin bad++; $display("FAIL run_sen_hold: got %0d want 1400", sen); end
  endtask

  task automatic test_recal_discard();
    pulse_recal();
    sends(12'd4095, 8);
    recal = 1'b1; sample_valid = 1'b1; sample_in = 12'd4095;
    tick();
    recal = 1'b0; sample_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy: got %b want 1", busy); end
    sends(12'd100, 15);
    total++; if (ref_valid !== 1'b0) begin bad++; $display("FAIL restart15_ref_valid: got %b want 0", ref_valid); end
    send(12'd100);
    total++; if (ref_level !== 12'd100) begin bad++; $display("FAIL restart_ref: got %0d want 100", ref_level); end
    total++; if (ref_valid !== 1'b1) begin bad++; $display("FAIL restart_ref_valid: got %b want 1", ref_valid); end
  endtask

  task automatic test_enable_drop();
    pulse_recal();
    sends(12'd500, 5);
    enable = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy: got %b want 0", busy); end
    total++; if (ref_valid !== 1'b0) begin bad++; $display("FAIL drop_ref_valid: got %b want 0", ref_valid); end
    total++; if (ref_level !== 12'd100) begin bad++; $display("FAIL drop_ref_hold: got %0d want 100", ref_level); end
    enable = 1'b1;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reenable_busy: got %b want 1", busy); end
    sends(12'd300, 15);
    total++; if (ref_valid !== 1'b0) begin bad++; $display("FAIL reenable15_ref_valid: got %b want 0", ref_valid); end
    send(12'd300);
    total++; if (ref_level !== 12'd300) begin bad++; $display("FAIL reenable_ref: got %0d want 300", ref_level); end
    total++; if (ref_valid !== 1'b1) begin bad++; $display("FAIL reenable_ref_valid: got %b want 1", ref_valid); end
    enable = 1'b0;
    tick();
    send(12'd4000);
    total++; if (sen !== 12'd300) begin bad++; $display("FAIL idle_sen_hold: got %0d want 300", sen); end
    total++; if (ref_valid !== 1'b1) begin bad++; $display("FAIL idle_ref_valid_hold: got %b want 1", ref_valid); end
    enable = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_to_run_busy: got %b want 0", busy); end
    send(12'd700);
    total++; if (sen !== 12'd400) begin bad++; $display("FAIL idle_to_run_sen: got %0d want 400", sen); end
  endtask

  task automatic test_drift_and_reset();
    logic [11:0] exp_ref;
`ifdef SENSOR_BASELINE_DRIFT_TRACK_EN
    exp_ref = 12'd1001;
`else
    exp_ref = 12'd1000;
`endif
    pulse_recal();
    sends(12'd1000, 16);
    sends(12'd1400, 15);
    total++; if (ref_level !== 12'd1000) begin bad++; $display("FAIL drift15_ref: got %0d want 1000", ref_level); end
    total++; if (sen !== 12'd1400) begin bad++; $display("FAIL drift_sen: got %0d want 1400", sen); end
    send(12'd1400);
    total++; if (ref_level !== exp_ref) begin bad++; $display("FAIL drift16_ref: got %0d want %0d", ref_level, exp_ref); end
    rst = 1'b1; recal = 1'b1; sample_valid = 1'b1; sample_in = 12'd1400;
    tick();
    total++; if (sen !== 12'd0) begin bad++; $display("FAIL rst2_sen: got %0d want 0", sen); end
    total++; if (ref_level !== 12'd0) begin bad++; $display("FAIL rst2_ref: got %0d want 0", ref_level); end
    total++; if (ref_valid !== 1'b0) begin bad++; $display("FAIL rst2_ref_valid: got %b want 0", ref_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst2_busy: got %b want 0", busy); end
    rst = 1'b0; recal = 1'b0; sample_valid = 1'b0;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL post_rst_busy: got %b want 1", busy); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; recal = 1'b0; sample_valid = 1'b0; sample_in = '0;
    test_reset();
    test_calib();
    test_calib_values();
    test_run_avg();
    test_recal_discard();
    test_enable_drop();
    test_drift_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
